// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared widths and fixed register indices for the register file block
package regfile_sb_pkg;
   localparam int DW_DEF       = 32;
   localparam int AW_DEF       = 5;
   localparam int LINK_REG_DEF = 31;
   localparam int ZERO_REG     = 0;
endpackage

// File: rtl/regfile_sb_busy.sv
// regfile_sb_busy: pending-write scoreboard, one busy bit per register plus HI and LO
//   clk, rst              clock, async active-high reset
//   set_en/set_addr       mark a register busy (address 0 ignored)
//   hilo_set              mark HI and LO busy
//   clr_en/clr_addr       write-back clears the written register
//   link_clr              link write clears the link register
//   hi_clr/lo_clr         HI/LO writes clear their bits
//   flush                 clear everything, overriding any set
//   busy, hi/lo_busy      registered busy state
//   *_byp                 registered state with this cycle's clears already applied
module regfile_sb_busy
   import regfile_sb_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int LINK_REG = LINK_REG_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic             hilo_set,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   input  logic             link_clr,
   input  logic             hi_clr,
   input  logic             lo_clr,
   input  logic             flush,
   output logic [2**AW-1:0] busy,
   output logic [2**AW-1:0] busy_byp,
   output logic             hi_busy,
   output logic             lo_busy,
   output logic             hi_busy_byp,
   output logic             lo_busy_byp
);
   localparam int N = 2**AW;
   logic [N-1:0] set_v, clr_v, busy_q;
   logic         hi_q, lo_q;
   always_comb begin
      set_v = '0;
      clr_v = '0;
      if (set_en && set_addr != AW'(ZERO_REG)) set_v[set_addr] = 1'b1;
      if (clr_en) clr_v[clr_addr] = 1'b1;
      if (link_clr) clr_v[LINK_REG] = 1'b1;
   end
   // set is ORed in after the clear so a newly issued producer wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         hi_q   <= 1'b0;
         lo_q   <= 1'b0;
      end else if (flush) begin
         busy_q <= '0;
         hi_q   <= 1'b0;
         lo_q   <= 1'b0;
      end else begin
         busy_q <= (busy_q & ~clr_v) | set_v;
         hi_q   <= (hi_q & ~hi_clr) | hilo_set;
         lo_q   <= (lo_q & ~lo_clr) | lo_set_of(hilo_set);
      end
   end
   function automatic logic lo_set_of(input logic s);
      return s;
   endfunction
   assign busy        = busy_q;
   assign hi_busy     = hi_q;
   assign lo_busy     = lo_q;
   // a clear that a same-cycle set overrides is not forwarded
   assign busy_byp    = busy_q & ~(clr_v & ~set_v);
   assign hi_busy_byp = hi_q & ~(hi_clr & ~hilo_set);
   assign lo_busy_byp = lo_q & ~(lo_clr & ~hilo_set);
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with HI/LO, optional write bypass and pending-write scoreboard
//   clk, rst                      clock, async active-high reset
//   rd_addr/rd_data/rd_busy       NRD packed read ports (port k at [k*AW +: AW] / [k*DW +: DW] / [k])
//   wr_en/wr_addr/wr_data         write-back port, also clears the target's busy bit
//   link_wr/link_data             write to LINK_REG, wins over a colliding write-back
//   hi_wr/hi_din, lo_wr/lo_din    HI/LO writes; hi_dout/lo_dout contents; hi_busy/lo_busy pending
//   sb_set/sb_addr, sb_hilo_set   mark registers / HI+LO busy
//   flush                         clear all busy bits
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int LINK_REG = LINK_REG_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*DW-1:0] rd_data,
   output logic [NRD-1:0]    rd_busy,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic              link_wr,
   input  logic [DW-1:0]     link_data,
   input  logic              hi_wr,
   input  logic              lo_wr,
   input  logic [DW-1:0]     hi_din,
   input  logic [DW-1:0]     lo_din,
   output logic [DW-1:0]     hi_dout,
   output logic [DW-1:0]     lo_dout,
   output logic              hi_busy,
   output logic              lo_busy,
   input  logic              sb_set,
   input  logic [AW-1:0]     sb_addr,
   input  logic              sb_hilo_set,
   input  logic              flush
);
   localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);
   localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
   logic [DW-1:0]     regs [2**AW];
   logic [DW-1:0]     hi_q, lo_q;
   logic [2**AW-1:0]  busy, busy_byp;
   logic              hi_b, lo_b, hi_b_byp, lo_b_byp;
   // link write is issued after the write-back so it wins on a collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (wr_en && wr_addr != ZERO_A) regs[wr_addr] <= wr_data;
         if (link_wr && LINK_A != ZERO_A) regs[LINK_A] <= link_data;
         if (hi_wr) hi_q <= hi_din;
         if (lo_wr) lo_q <= lo_din;
      end
   end
   regfile_sb_busy #(.AW(AW), .LINK_REG(LINK_REG)) u_busy (
      .clk         (clk),
      .rst         (rst),
      .set_en      (sb_set),
      .set_addr    (sb_addr),
      .hilo_set    (sb_hilo_set),
      .clr_en      (wr_en),
      .clr_addr    (wr_addr),
      .link_clr    (link_wr),
      .hi_clr      (hi_wr),
      .lo_clr      (lo_wr),
      .flush       (flush),
      .busy        (busy),
      .busy_byp    (busy_byp),
      .hi_busy     (hi_b),
      .lo_busy     (lo_b),
      .hi_busy_byp (hi_b_byp),
      .lo_busy_byp (lo_b_byp)
   );
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic [DW-1:0] fwd;
      assign a = rd_addr[k*AW +: AW];
      always_comb begin
         fwd = regs[a];
         if (BYPASS != 0 && wr_en && a == wr_addr) fwd = wr_data;
         if (BYPASS != 0 && link_wr && a == LINK_A) fwd = link_data;
      end
      assign rd_data[k*DW +: DW] = (a == ZERO_A) ? '0 : fwd;
      assign rd_busy[k] = (a == ZERO_A) ? 1'b0 : (BYPASS != 0 ? busy_byp[a] : busy[a]);
   end
   assign hi_dout = (BYPASS != 0 && hi_wr) ? hi_din : hi_q;
   assign lo_dout = (BYPASS != 0 && lo_wr) ? lo_din : lo_q;
   assign hi_busy = BYPASS != 0 ? hi_b_byp : hi_b;
   assign lo_busy = BYPASS != 0 ? lo_b_byp : lo_b;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven check of bypass and non-bypass register files side by side
module tb_regfile_sb;
   typedef struct {
      logic [4:0]  ra0, ra1;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        lw;
      logic [31:0] ld;
      logic        hw;
      logic [31:0] hd;
      logic        low;
      logic [31:0] lod;
      logic        ss;
      logic [4:0]  sa;
      logic        hs;
      logic        fl;
   } in_t;
   typedef struct {
      logic [31:0] r0, r1;
      logic [1:0]  b;
      logic [31:0] hi, lo;
      logic        hb, lb;
   } out_t;
   typedef struct {
      in_t  i;
      out_t e1, e0;
   } vec_t;

   logic        clk = 0, rst = 1;
   logic [9:0]  rd_addr;
   logic        wr_en, link_wr, hi_wr, lo_wr, sb_set, sb_hilo_set, flush;
   logic [4:0]  wr_addr, sb_addr;
   logic [31:0] wr_data, link_data, hi_din, lo_din;
   logic [63:0] rd_data1, rd_data0;
   logic [1:0]  rd_busy1, rd_busy0;
   logic [31:0] hi_dout1, lo_dout1, hi_dout0, lo_dout0;
   logic        hi_busy1, lo_busy1, hi_busy0, lo_busy0;
   int          n_vec = 0, n_miss = 0;
   vec_t        tbl[$];
   out_t        q1[$], q0[$];

   always #5 clk = ~clk;

   regfile_sb #(.BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_wr(link_wr), .link_data(link_data),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_din(hi_din), .lo_din(lo_din), .hi_dout(hi_dout1), .lo_dout(lo_dout1),
      .hi_busy(hi_busy1), .lo_busy(lo_busy1), .sb_set(sb_set), .sb_addr(sb_addr),
      .sb_hilo_set(sb_hilo_set), .flush(flush));
   regfile_sb #(.BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_wr(link_wr), .link_data(link_data),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_din(hi_din), .lo_din(lo_din), .hi_dout(hi_dout0), .lo_dout(lo_dout0),
      .hi_busy(hi_busy0), .lo_busy(lo_busy0), .sb_set(sb_set), .sb_addr(sb_addr),
      .sb_hilo_set(sb_hilo_set), .flush(flush));

   function automatic in_t rd(input logic [4:0] a0, input logic [4:0] a1);
      in_t i;
      i = '{default: '0};
      i.ra0 = a0;
      i.ra1 = a1;
      return i;
   endfunction

   function automatic out_t o(input logic [31:0] r0, input logic [31:0] r1, input logic [1:0] b,
                              input logic [31:0] hi, input logic [31:0] lo, input logic hb, input logic lb);
      out_t x;
      x.r0 = r0; x.r1 = r1; x.b = b; x.hi = hi; x.lo = lo; x.hb = hb; x.lb = lb;
      return x;
   endfunction

   task automatic add(input in_t i, input out_t e1, input out_t e0);
      vec_t v;
      v.i = i; v.e1 = e1; v.e0 = e0;
      tbl.push_back(v);
   endtask

   task automatic drive(input in_t i);
      rd_addr = {i.ra1, i.ra0};
      wr_en = i.we; wr_addr = i.wa; wr_data = i.wd;
      link_wr = i.lw; link_data = i.ld;
      hi_wr = i.hw; hi_din = i.hd; lo_wr = i.low; lo_din = i.lod;
      sb_set = i.ss; sb_addr = i.sa; sb_hilo_set = i.hs; flush = i.fl;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cmp(input string tag, input out_t a, input out_t e);
      check({tag, ".rd0"}, a.r0, e.r0);
      check({tag, ".rd1"}, a.r1, e.r1);
      check({tag, ".busy"}, 32'(a.b), 32'(e.b));
      check({tag, ".hi"}, a.hi, e.hi);
      check({tag, ".lo"}, a.lo, e.lo);
      check({tag, ".hi_busy"}, 32'(a.hb), 32'(e.hb));
      check({tag, ".lo_busy"}, 32'(a.lb), 32'(e.lb));
   endtask

   task automatic compare_both(input string tag);
      out_t e1, e0, a1, a0;
      if (q1.size() == 0 || q0.size() == 0) begin
         check({tag, ".queue_empty"}, 32'(q1.size() + q0.size()), 32'd2);
         return;
      end
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      a1 = o(rd_data1[31:0], rd_data1[63:32], rd_busy1, hi_dout1, lo_dout1, hi_busy1, lo_busy1);
      a0 = o(rd_data0[31:0], rd_data0[63:32], rd_busy0, hi_dout0, lo_dout0, hi_busy0, lo_busy0);
      cmp({tag, ".byp1"}, a1, e1);
      cmp({tag, ".byp0"}, a0, e0);
   endtask

   initial begin
      in_t i;
      out_t z;
      z = o(0, 0, 0, 0, 0, 0, 0);
      // C1-C8: write, r0, link collision, dual-port bypass
      i = rd(5, 5); i.we = 1; i.wa = 5; i.wd = 'h1234;
      add(i, o('h1234, 'h1234, 0, 0, 0, 0, 0), z);
      add(rd(5, 5), o('h1234, 'h1234, 0, 0, 0, 0, 0), o('h1234, 'h1234, 0, 0, 0, 0, 0));
      i = rd(0, 0); i.we = 1; i.wa = 0; i.wd = 'hFFFF;
      add(i, z, z);
      add(rd(0, 5), o(0, 'h1234, 0, 0, 0, 0, 0), o(0, 'h1234, 0, 0, 0, 0, 0));
      i = rd(31, 31); i.we = 1; i.wa = 31; i.wd = 'hAAAA; i.lw = 1; i.ld = 'h5555;
      add(i, o('h5555, 'h5555, 0, 0, 0, 0, 0), z);
      add(rd(31, 5), o('h5555, 'h1234, 0, 0, 0, 0, 0), o('h5555, 'h1234, 0, 0, 0, 0, 0));
      i = rd(7, 7); i.we = 1; i.wa = 7; i.wd = 'hDEAD;
      add(i, o('hDEAD, 'hDEAD, 0, 0, 0, 0, 0), z);
      add(rd(7, 7), o('hDEAD, 'hDEAD, 0, 0, 0, 0, 0), o('hDEAD, 'hDEAD, 0, 0, 0, 0, 0));
      // C9-C17: scoreboard set, clear, set-wins, address 0
      i = rd(9, 9); i.ss = 1; i.sa = 9;
      add(i, z, z);
      add(rd(9, 9), o(0, 0, 3, 0, 0, 0, 0), o(0, 0, 3, 0, 0, 0, 0));
      i = rd(9, 9); i.we = 1; i.wa = 9; i.wd = 'h99;
      add(i, o('h99, 'h99, 0, 0, 0, 0, 0), o(0, 0, 3, 0, 0, 0, 0));
      add(rd(9, 9), o('h99, 'h99, 0, 0, 0, 0, 0), o('h99, 'h99, 0, 0, 0, 0, 0));
      i = rd(9, 9); i.ss = 1; i.sa = 9;
      add(i, o('h99, 'h99, 0, 0, 0, 0, 0), o('h99, 'h99, 0, 0, 0, 0, 0));
      i = rd(9, 9); i.ss = 1; i.sa = 9; i.we = 1; i.wa = 9; i.wd = 'hAB;
      add(i, o('hAB, 'hAB, 3, 0, 0, 0, 0), o('h99, 'h99, 3, 0, 0, 0, 0));
      add(rd(9, 9), o('hAB, 'hAB, 3, 0, 0, 0, 0), o('hAB, 'hAB, 3, 0, 0, 0, 0));
      i = rd(0, 0); i.ss = 1; i.sa = 0;
      add(i, z, z);
      add(rd(0, 0), z, z);
      // C18-C21: HI/LO
      i = rd(5, 5); i.hs = 1;
      add(i, o('h1234, 'h1234, 0, 0, 0, 0, 0), o('h1234, 'h1234, 0, 0, 0, 0, 0));
      i = rd(5, 5); i.hw = 1; i.hd = 'h11;
      add(i, o('h1234, 'h1234, 0, 'h11, 0, 0, 1), o('h1234, 'h1234, 0, 0, 0, 1, 1));
      i = rd(5, 5); i.low = 1; i.lod = 'h22;
      add(i, o('h1234, 'h1234, 0, 'h11, 'h22, 0, 0), o('h1234, 'h1234, 0, 'h11, 0, 0, 1));
      add(rd(5, 5), o('h1234, 'h1234, 0, 'h11, 'h22, 0, 0), o('h1234, 'h1234, 0, 'h11, 'h22, 0, 0));
      // C22-C27: flush beats set, write still lands
      i = rd(3, 4); i.ss = 1; i.sa = 3;
      add(i, o(0, 0, 0, 'h11, 'h22, 0, 0), o(0, 0, 0, 'h11, 'h22, 0, 0));
      i = rd(3, 4); i.ss = 1; i.sa = 4; i.hs = 1;
      add(i, o(0, 0, 1, 'h11, 'h22, 0, 0), o(0, 0, 1, 'h11, 'h22, 0, 0));
      add(rd(3, 4), o(0, 0, 3, 'h11, 'h22, 1, 1), o(0, 0, 3, 'h11, 'h22, 1, 1));
      i = rd(3, 6); i.fl = 1; i.ss = 1; i.sa = 6; i.we = 1; i.wa = 3; i.wd = 'h77;
      add(i, o('h77, 0, 0, 'h11, 'h22, 1, 1), o(0, 0, 1, 'h11, 'h22, 1, 1));
      add(rd(3, 6), o('h77, 0, 0, 'h11, 'h22, 0, 0), o('h77, 0, 0, 'h11, 'h22, 0, 0));
      add(rd(9, 4), o('hAB, 0, 0, 'h11, 'h22, 0, 0), o('hAB, 0, 0, 'h11, 'h22, 0, 0));
      // C28-C30: link write clears the link register's busy bit
      i = rd(31, 31); i.ss = 1; i.sa = 31;
      add(i, o('h5555, 'h5555, 0, 'h11, 'h22, 0, 0), o('h5555, 'h5555, 0, 'h11, 'h22, 0, 0));
      i = rd(31, 31); i.lw = 1; i.ld = 'h4242;
      add(i, o('h4242, 'h4242, 0, 'h11, 'h22, 0, 0), o('h5555, 'h5555, 3, 'h11, 'h22, 0, 0));
      add(rd(31, 31), o('h4242, 'h4242, 0, 'h11, 'h22, 0, 0), o('h4242, 'h4242, 0, 'h11, 'h22, 0, 0));

      // reset state
      drive(rd(5, 31));
      repeat (2) @(negedge clk);
      q1.push_back(z); q0.push_back(z);
      compare_both("reset");
      rst = 0;
      foreach (tbl[n]) begin
         @(negedge clk);
         drive(tbl[n].i);
         q1.push_back(tbl[n].e1);
         q0.push_back(tbl[n].e0);
         #2;
         compare_both($sformatf("vec%0d", n));
      end

      // async reset mid-cycle with busy state and live data present
      @(negedge clk);
      i = rd(5, 9); i.ss = 1; i.sa = 5; i.hs = 1;
      drive(i);
      @(negedge clk);
      drive(rd(5, 31));
      #1;
      q1.push_back(o('h1234, 'h4242, 1, 'h11, 'h22, 1, 1));
      q0.push_back(o('h1234, 'h4242, 1, 'h11, 'h22, 1, 1));
      compare_both("pre_rst");
      rst = 1;
      #1;
      q1.push_back(z); q0.push_back(z);
      compare_both("rst_async");
      // a write presented while reset is held must be discarded
      @(negedge clk);
      i = rd(5, 31); i.we = 1; i.wa = 5; i.wd = 'hBEEF; i.hw = 1; i.hd = 'hFF;
      drive(i);
      @(negedge clk);
      drive(rd(5, 31));
      rst = 0;
      #1;
      q1.push_back(z); q0.push_back(z);
      compare_both("rst_discard");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the CPU register file and the HI/LO pair, merged into one block with three additions: N read ports, optional write-to-read bypass, and a pending-write scoreboard. The scoreboard lets multi-cycle producers (mul/div, loads) mark destinations busy so the decode/hazard logic can stall. It sits between decode (reads, scoreboard set) and write-back (writes, scoreboard clear).

Parameters:
DW, 32, data width of every register including HI/LO
AW, 5, register address width; depth = 2**AW, register 0 hard-wired to zero
NRD, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads and busy flags; 0 = writes visible next cycle only
LINK_REG, 31, index written by the link port

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_addr  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
rd_data  out  NRD*DW  packed read data
rd_busy  out  NRD  read register has a pending producer
wr_en  in  1  write-back enable
wr_addr  in  AW  write-back address
wr_data  in  DW  write-back data
link_wr  in  1  link-register write enable
link_data  in  DW  link-register data
hi_wr / lo_wr  in  1 each  HI / LO write enables
hi_din / lo_din  in  DW each  HI / LO write data
hi_dout / lo_dout  out  DW each  HI / LO contents
hi_busy / lo_busy  out  1 each  HI / LO pending producer
sb_set  in  1  mark sb_addr busy
sb_addr  in  AW  scoreboard target
sb_hilo_set  in  1  mark HI and LO busy
flush  in  1  clear all busy bits (pipeline squash)

Behaviour:
- Reset (async, rst high): all 2**AW registers, HI, LO, and all busy bits go to 0. Consequently rd_data, hi_dout, lo_dout and all busy outputs read 0. Reset asserted mid-operation discards any pending write in that cycle.
- Reads are combinational; rd_data of port k equals reg[rd_addr_k]. Address 0 always returns 0 and rd_busy 0.
- Writes take effect at the rising edge:
  - reg[wr_addr] <= wr_data when wr_en.
  - reg[LINK_REG] <= link_data when link_wr.
  - HI/LO update independently on hi_wr / lo_wr.
- Writes to address 0 are ignored, from either port.
- Collision: wr_en and link_wr both target LINK_REG in the same cycle → link_data wins.
- BYPASS=1:
  - A read of an address written this cycle returns the incoming data, with the link-wins rule applied.
  - hi_dout/lo_dout return hi_din/lo_din while hi_wr/lo_wr is high.
  - The busy flag for a register being cleared this cycle reads 0.
- BYPASS=0: reads return the pre-edge value; new data is visible exactly 1 cycle after the write.
- Scoreboard, one busy bit per register plus hi_busy and lo_busy:
  - Set at the edge: sb_set sets busy[sb_addr]; sb_hilo_set sets both HI and LO busy.
  - Clear at the edge: a wr_en write to an address clears its bit; link_wr clears busy[LINK_REG]; hi_wr clears hi_busy; lo_wr clears lo_busy.
  - Set and clear of the same bit in the same cycle → set wins (a new producer was issued).
  - sb_set to address 0 is ignored.
  - flush clears every busy bit at the edge. flush has priority over any set in the same cycle. Register and HI/LO data writes in a flush cycle still occur.
  - Setting an already-busy bit is idempotent; there is no counting of outstanding producers.
- No internal latency beyond one register stage; no stalls generated internally.

Decomposition:
- Shared package holds the default widths (DW, AW), the LINK_REG index, and the ZERO_REG constant.
- One natural sub-module, regfile_sb_busy: the scoreboard bit-vector with its set/clear/flush priority logic.
- Storage, read muxing and bypass stay in the top module.

Test Plan:
- Reset: pulse rst after writing r5=0x1234 → rd_data(r5)=0, hi_dout=lo_dout=0, all busy flags 0. rst is asserted between edges and the outputs clear immediately.
- r0 and link priority: wr_en to r0 with 0xFFFF → r0 reads 0. Same cycle wr_en r31=0xAAAA and link_wr 0x5555 → r31=0x5555 next cycle, and also in the same cycle when BYPASS=1.
- Bypass: wr_en r7=0xDEAD while port 0 and port 1 both read r7 → with BYPASS=1 both show 0xDEAD in that cycle. With BYPASS=0 both show the old value, then 0xDEAD one cycle later.
- Scoreboard: sb_set r9 → rd_busy(r9)=1 from the next cycle. A later wr_en r9 clears it: busy reads 0 in the write cycle when BYPASS=1, and from the next cycle when BYPASS=0. sb_set r9 together with wr_en r9 → busy stays 1.
- HI/LO: sb_hilo_set → hi_busy=lo_busy=1. hi_wr 0x11 → hi_busy=0, lo_busy=1, hi_dout=0x11, lo_dout unchanged. lo_wr 0x22 → lo_busy=0.
- Flush: busy on r3, r4 and HI; assert flush together with sb_set r6 → all busy 0, r6 not busy. A wr_en r3=0x77 in the same cycle still lands.
